// File: rtl/bcd_counter_ndigit.sv
// Multi-digit BCD up/down counter with clear, parallel load, carry/borrow chain and sticky overflow.
// Optional capture register and ports enabled by defining BCD_LATCH_EN.
module bcd_counter_ndigit #(
    parameter int DIGITS   = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  up_dn,
`ifdef BCD_LATCH_EN
    input  logic                  latch,
    output logic [4*DIGITS-1:0]   bcd_latched,
`endif
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  carryout,
    output logic                  overflow
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0] r_bcd;
    logic         r_overflow;
    logic [W-1:0] w_step_val;
    logic [W-1:0] w_load_val;
    logic         w_all9;
    logic         w_all0;
    logic [W-1:0] w_next_bcd;
    logic         w_next_overflow;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [3:0] inc_digit(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] dec_digit(input logic [3:0] d);
        return ((d == 4'd0) || (d > 4'd9)) ? 4'd9 : d - 4'd1;
    endfunction

    // Carry/borrow chain: a digit steps when every lower digit sits at its terminal value.
    always_comb begin
        w_all9     = 1'b1;
        w_all0     = 1'b1;
        w_step_val = r_bcd;
        w_load_val = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_load_val[4*i +: 4] = clamp_digit(load_val[4*i +: 4]);
            if (up_dn ? w_all9 : w_all0) begin
                w_step_val[4*i +: 4] = up_dn ? inc_digit(r_bcd[4*i +: 4])
                                             : dec_digit(r_bcd[4*i +: 4]);
            end else begin
                w_step_val[4*i +: 4] = r_bcd[4*i +: 4];
            end
            w_all9 = w_all9 & (r_bcd[4*i +: 4] == 4'd9);
            w_all0 = w_all0 & (r_bcd[4*i +: 4] == 4'd0);
        end
    end

    assign carryout = en & ((up_dn & w_all9) | (~up_dn & w_all0));

    // Next-state selection with priority clr > load > en.
    always_comb begin
        w_next_bcd      = r_bcd;
        w_next_overflow = r_overflow;
        if (clr) begin
            w_next_bcd      = {W{1'b0}};
            w_next_overflow = 1'b0;
        end else if (load) begin
            w_next_bcd      = w_load_val;
        end else if (en) begin
            if (carryout) begin
                w_next_overflow = 1'b1;
                if (SATURATE == 1'b0) begin
                    w_next_bcd = w_step_val;
                end else begin
                    w_next_bcd = r_bcd;
                end
            end else begin
                w_next_bcd = w_step_val;
            end
        end else begin
            w_next_bcd = r_bcd;
        end
    end

    // Count and sticky overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd      <= {W{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            r_bcd      <= w_next_bcd;
            r_overflow <= w_next_overflow;
        end
    end

    assign bcd      = r_bcd;
    assign overflow = r_overflow;

`ifdef BCD_LATCH_EN
    logic [W-1:0] r_bcd_latched;

    // Snapshot of the pre-edge count; independent of clr and load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd_latched <= {W{1'b0}};
        end else if (latch) begin
            r_bcd_latched <= r_bcd;
        end else begin
            r_bcd_latched <= r_bcd_latched;
        end
    end

    assign bcd_latched = r_bcd_latched;
`endif

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Directed self-checking bench: wrap-mode and saturate-mode instances share all inputs.
module tb_bcd_counter_ndigit;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        load;
    logic [15:0] load_val;
    logic        up_dn;
    logic [15:0] bcd_w, bcd_s;
    logic        co_w, co_s;
    logic        ovf_w, ovf_s;
`ifdef BCD_LATCH_EN
    logic        latch;
    logic [15:0] lat_w, lat_s;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    bcd_counter_ndigit #(.DIGITS(4), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .up_dn(up_dn),
`ifdef BCD_LATCH_EN
        .latch(latch), .bcd_latched(lat_w),
`endif
        .bcd(bcd_w), .carryout(co_w), .overflow(ovf_w)
    );

    bcd_counter_ndigit #(.DIGITS(4), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .up_dn(up_dn),
`ifdef BCD_LATCH_EN
        .latch(latch), .bcd_latched(lat_s),
`endif
        .bcd(bcd_s), .carryout(co_s), .overflow(ovf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    task automatic do_load(input logic [15:0] v);
        load     = 1'b1;
        load_val = v;
        tick();
        load     = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0;
        load_val = 16'h0000; up_dn = 1'b1;
`ifdef BCD_LATCH_EN
        latch = 1'b0;
`endif
        tick();
        tick();
        rst_n = 1'b1;
        check_val("reset_bcd", 32'(bcd_w), 32'h0000);
        check_val("reset_ovf", 32'(ovf_w), 32'h0);
        check_val("reset_bcd_sat", 32'(bcd_s), 32'h0000);
`ifdef BCD_LATCH_EN
        check_val("reset_latched", 32'(lat_w), 32'h0000);
`endif

        // Full up-count sweep through the wrap.
        en = 1'b1; up_dn = 1'b1;
        #1;
        for (int k = 0; k < 10000; k++) begin
            check_val("sweep_bcd", 32'(bcd_w), 32'(to_bcd(k)));
            check_val("sweep_co", 32'(co_w), (k == 9999) ? 32'h1 : 32'h0);
            tick();
        end
        check_val("wrap_bcd", 32'(bcd_w), 32'h0000);
        check_val("wrap_ovf", 32'(ovf_w), 32'h1);
        check_val("sat_hold_bcd", 32'(bcd_s), 32'h9999);
        check_val("sat_hold_ovf", 32'(ovf_s), 32'h1);

        // Load then count up across digit boundaries, plus clamping.
        en = 1'b0;
        do_load(16'h0099);
        check_val("load_0099", 32'(bcd_w), 32'h0099);
        en = 1'b1;
        tick();
        check_val("up_0100", 32'(bcd_w), 32'h0100);
        tick();
        check_val("up_0101", 32'(bcd_w), 32'h0101);
        en = 1'b0;
        do_load(16'h00AF);
        check_val("clamp_00AF", 32'(bcd_w), 32'h0099);
        check_val("load_keeps_ovf", 32'(ovf_w), 32'h1);
        do_load(16'hF9A3);
        check_val("clamp_F9A3", 32'(bcd_w), 32'h9993);

        // Clear, then down-count underflow in both modes.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_val("clr_bcd", 32'(bcd_w), 32'h0000);
        check_val("clr_ovf", 32'(ovf_w), 32'h0);
        do_load(16'h0000);
        en = 1'b1; up_dn = 1'b0;
        #1;
        check_val("down_co", 32'(co_w), 32'h1);
        check_val("down_co_sat", 32'(co_s), 32'h1);
        tick();
        check_val("under_bcd", 32'(bcd_w), 32'h9999);
        check_val("under_ovf", 32'(ovf_w), 32'h1);
        check_val("sat_under_bcd", 32'(bcd_s), 32'h0000);
        check_val("sat_under_ovf", 32'(ovf_s), 32'h1);

        // clr beats load and en at terminal count.
        en = 1'b1; up_dn = 1'b1; clr = 1'b1; load = 1'b1; load_val = 16'h1234;
        tick();
        clr = 1'b0; load = 1'b0;
        check_val("clr_prio_bcd", 32'(bcd_w), 32'h0000);
        check_val("clr_prio_ovf", 32'(ovf_w), 32'h0);

        // Asynchronous reset mid-count.
        do_load(16'h0456);
        tick();
        check_val("count_0457", 32'(bcd_w), 32'h0457);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst", 32'(bcd_w), 32'h0000);
        en = 1'b0;
        tick();
        rst_n = 1'b1;

        // Direction flip and borrow across digits.
        do_load(16'h0100);
        en = 1'b1; up_dn = 1'b0;
        tick();
        check_val("flip_0099", 32'(bcd_w), 32'h0099);
        en = 1'b0;
        do_load(16'h1000);
        en = 1'b1;
        tick();
        check_val("borrow_0999", 32'(bcd_w), 32'h0999);

        // Hold with en low at 9999.
        en = 1'b0; up_dn = 1'b1;
        do_load(16'h9999);
        for (int k = 0; k < 5; k++) begin
            check_val("hold_bcd", 32'(bcd_w), 32'h9999);
            check_val("hold_co", 32'(co_w), 32'h0);
            tick();
        end
        en = 1'b1;
        #1;
        check_val("en_co", 32'(co_w), 32'h1);
        en = 1'b0;

`ifdef BCD_LATCH_EN
        // Latch and clear on the same edge keep the count.
        do_load(16'h0321);
        latch = 1'b1; clr = 1'b1;
        tick();
        latch = 1'b0; clr = 1'b0;
        check_val("latch_val", 32'(lat_w), 32'h0321);
        check_val("latch_clr_bcd", 32'(bcd_w), 32'h0000);
        do_load(16'h0555);
        check_val("latch_after_load", 32'(lat_w), 32'h0321);
        check_val("load_0555", 32'(bcd_w), 32'h0555);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_counter_ndigit.md
Name: bcd_counter_ndigit

Overview:
Parametrised multi-digit BCD up/down counter with count-enable, synchronous clear, parallel load, ripple-free carry/borrow chain, sticky overflow and optional wrap/saturate mode. Successor to the single-digit BCD counter. Used as the event accumulator in counter/gate-timer designs, e.g. the MPPC dark-count front end, driving multiplexed 7-segment display logic.

Parameters:
DIGITS, 4, number of BCD digits (1..8); total count width 4*DIGITS.
SATURATE, 0, 0 = wrap at 99..9 / 00..0; 1 = hold at terminal value.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
en  input  1  count enable, one step per clock while high
clr  input  1  synchronous clear of count and overflow
load  input  1  synchronous parallel load
load_val  input  4*DIGITS  load value, digit i at bits [4i+3:4i]
up_dn  input  1  1 = count up, 0 = count down
bcd  output  4*DIGITS  registered count, digit 0 = least significant
carryout  output  1  combinational terminal-count flag for cascading
overflow  output  1  registered sticky wrap/saturate-attempt flag

Behaviour:
- Reset (rst_n low, asynchronous): bcd = all zeros, overflow = 0; bcd_latched = 0 when BCD_LATCH_EN is defined. Release synchronous to clk, counting from next edge.
- Per-edge priority: clr > load > en. en low with clr/load low: hold.
- clr: bcd <= 0, overflow <= 0, regardless of en/load.
- load: each digit <= load_val digit; digits > 9 are clamped to 9. overflow unchanged.
- Count up (en=1, up_dn=1): digit i increments iff all digits j<i equal 9; a digit at 9 that steps goes to 0. Digit 0 always steps.
- Count down (en=1, up_dn=0): digit i decrements iff all digits j<i equal 0; a digit at 0 that steps goes to 9.
- carryout = en & ((up_dn & all digits 9) | (~up_dn & all digits 0)). Combinational, asserted in the cycle before the wrap edge, same as the single-digit block. Not gated by clr/load.
- Terminal step (carryout=1, clr=0, load=0):
  - SATURATE=0: counter wraps (99..9 -> 00..0 or 00..0 -> 99..9).
  - SATURATE=1: counter holds its value.
  - In both modes overflow <= 1.
- overflow stays set until clr or reset. load does not clear it.
- up_dn may change on any cycle. The new direction applies to the same edge; no pipeline.
- Latency: load/clr/step visible on bcd one clock after the edge. No internal state beyond the digit and flag registers.
- bcd never holds a non-BCD digit (A..F) under any input sequence.

Optional Feature:
Macro BCD_LATCH_EN.
- Defined: extra ports latch (input, 1) and bcd_latched (output, 4*DIGITS).
  - On an edge with latch=1, bcd_latched captures the pre-edge bcd value (the value visible on bcd during the latch cycle).
  - If clr occurs on the same edge, the capture still happens, so a gate-end latch + clr never loses the count.
  - bcd_latched is unaffected by clr and load; reset sets it to 0.
- Not defined: ports and register absent; behaviour otherwise identical.

Test Plan:
1. DIGITS=4, reset then en=1, up_dn=1 for 10000 cycles -> bcd steps 0000..9999. carryout=1 only while bcd=9999. Final bcd=0000, overflow=1.
2. load_val=0x0099, load=1, then en=1 up -> 0100, then 0101. load_val=0x00AF loads as 0x0099.
3. load 0x0000, en=1, up_dn=0 -> carryout=1 in load-following cycle, next bcd=9999, overflow=1. SATURATE=1 rerun -> bcd stays 0000, overflow=1.
4. At bcd=9999, en=1, clr=1 and load=1 together -> bcd=0000, overflow=0 (clr wins). Toggle rst_n low mid-count at 0457 -> immediate 0000, no clk needed.
5. Direction flip at 0100: up_dn 1->0 with en=1 -> 0099 on the next edge. en=0 for 5 cycles -> bcd held, carryout=0 even at 9999.
6. BCD_LATCH_EN defined: count to 0321, assert latch and clr on the same edge -> bcd_latched=0321, bcd=0000. Later load -> bcd_latched unchanged.
